// File: rtl/dmem_sized.sv
// dmem_sized: data memory for the single-cycle RV32I core.
//   Byte-, half- and word-sized loads and stores, with little-endian byte lanes.
//   Loads are combinational. Stores commit on posedge.
//   After reset, a sequencer clears the whole array one word per clock and
//   holds busy=1 until it has finished.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   WE               store enable
//   A, WD            byte address, store data
//   funct3           access size (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   RD               load result, sign- or zero-extended
//   misalign         misaligned access or illegal funct3
//   range_err        A is outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)
//   busy             clear sequence in progress
module dmem_sized #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [2:0]  funct3,
  output logic [31:0] RD,
  output logic        misalign,
  output logic        range_err,
  output logic        busy
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Compare in 33 bits so that a window reaching 2^32 does not wrap.
  localparam logic [32:0] BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t         r_state, w_state_n;
  logic [AW-1:0]  r_cnt, w_cnt_n;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic [31:0]    w_off;
  logic           w_in_range;
  logic [AW-1:0]  w_idx;
  logic [31:0]    w_word;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic           w_st_en;
  logic           w_clr;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata;

  // ---------------- address decode ----------------
  assign w_off      = A - BASE_ADDR;
  assign w_in_range = (A >= BASE_ADDR) && ({1'b0, w_off} < BYTES);
  assign w_idx      = w_off[AW+1:2];
  assign range_err  = !w_in_range;

  always_comb begin
    misalign = 1'b0;
    case (funct3)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = w_off[0];
      3'b010:         misalign = (w_off[1:0] != 2'b00);
      default:        misalign = 1'b1;
    endcase
  end

  assign busy = (r_state == CLEAR);

  // ---------------- load path ----------------
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off[1:0], 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    RD = '0;
    if (!misalign && w_in_range && !busy) begin
      case (funct3)
        3'b000:  RD = {{24{w_byte[7]}}, w_byte};
        3'b001:  RD = {{16{w_half[15]}}, w_half};
        3'b010:  RD = w_word;
        3'b100:  RD = {24'd0, w_byte};
        3'b101:  RD = {16'd0, w_half};
        default: RD = '0;
      endcase
    end
  end

  // ---------------- store path ----------------
  assign w_st_en = WE && !busy && !rst && !misalign && w_in_range;
  assign w_clr   = busy && !rst;

  // Replicate the store data across all lanes, so that the byte enables
  // alone decide which lanes are written.
  always_comb begin
    w_be    = '0;
    w_wdata = WD;
    case (funct3)
      3'b000: begin
        w_be    = 4'b0001 << w_off[1:0];
        w_wdata = {4{WD[7:0]}};
      end
      3'b001: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD[15:0]}};
      end
      3'b010:  w_be = 4'b1111;
      default: w_be = '0;
    endcase
    if (!w_st_en) w_be = '0;
  end

  // A clear and a store never coincide, because a store requires !busy.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (r_state == CLEAR) begin
      if (r_cnt == LAST) begin
        w_state_n = READY;
        w_cnt_n   = '0;
      end else begin
        w_cnt_n = r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
module tb_dmem_sized;
  logic        clk = 1'b0;
  logic        rst;
  logic        WE;
  logic [31:0] A, WD;
  logic [2:0]  funct3;
  logic [31:0] RD;
  logic        misalign, range_err, busy;

  logic [31:0] A2;
  logic [31:0] RD2;
  logic        misalign2, range_err2, busy2;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  dmem_sized #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .WD(WD), .funct3(funct3),
    .RD(RD), .misalign(misalign), .range_err(range_err), .busy(busy));

  dmem_sized #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h2000)) dut_hi (
    .clk(clk), .rst(rst), .WE(1'b0), .A(A2), .WD(32'h0), .funct3(3'b010),
    .RD(RD2), .misalign(misalign2), .range_err(range_err2), .busy(busy2));

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        chk_rd;
    logic [31:0] rd;
    logic        mis;
    logic        rng;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] wd, logic [2:0] f3,
                              logic chk_rd, logic [31:0] rd, logic mis, logic rng);
    vec_t v;
    v.we = we; v.a = a; v.wd = wd; v.f3 = f3;
    v.chk_rd = chk_rd; v.rd = rd; v.mis = mis; v.rng = rng;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3);
    WE = 1'b0; A = a; funct3 = f3; WD = '0;
    #2;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    WE = 1'b1; A = a; WD = wd; funct3 = f3;
    tick();
    WE = 1'b0;
  endtask

  // Counts the posedges until busy drops, and flags any nonzero RD seen on the way.
  task automatic wait_clear(input string name);
    int  n;
    bit  rd_bad;
    n = 0; rd_bad = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (RD !== 32'h0) rd_bad = 1;
      tick();
      n++;
    end
    WE = 1'b0;
    chk({name, "_edges"}, 32'(n), 32'd1024);
    chk({name, "_rd_zero_while_busy"}, {31'd0, rd_bad}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; WE = 1'b0; A = '0; WD = '0; funct3 = 3'b010; A2 = '0;

    // Clear sequence. A store to 0x8 is held on during reset and busy;
    // it must never land.
    @(negedge clk);
    WE = 1'b1; A = 32'h8; WD = 32'h1111_1111; funct3 = 3'b010;
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_rd",   RD, 32'd0);
    tick();
    chk("hold_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    wait_clear("clear1");
    chk("busy_after_clear", {31'd0, busy}, 32'd0);
    load(32'h8, 3'b010);   chk("busy_store_dropped", RD, 32'd0);
    load(32'h3FC, 3'b010); chk("lw_3fc_cleared",     RD, 32'd0);

    // Directed vectors (RD is sampled before the edge, for stores too).
    tbl.push_back(mk(1, 32'h100, 32'h80FF7F01, 3'b010, 1, 32'h0,        0, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b010, 1, 32'h80FF7F01, 0, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b000, 1, 32'h00000001, 0, 0));
    tbl.push_back(mk(0, 32'h101, 32'h0,        3'b000, 1, 32'h0000007F, 0, 0));
    tbl.push_back(mk(0, 32'h102, 32'h0,        3'b000, 1, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(0, 32'h102, 32'h0,        3'b100, 1, 32'h000000FF, 0, 0));
    tbl.push_back(mk(0, 32'h102, 32'h0,        3'b001, 1, 32'hFFFF80FF, 0, 0));
    tbl.push_back(mk(0, 32'h102, 32'h0,        3'b101, 1, 32'h000080FF, 0, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b001, 1, 32'h00007F01, 0, 0));
    tbl.push_back(mk(1, 32'h103, 32'h000000AB, 3'b000, 1, 32'hFFFFFF80, 0, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b010, 1, 32'hABFF7F01, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'hCAFE1234, 3'b001, 1, 32'h00007F01, 0, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b010, 1, 32'hABFF1234, 0, 0));
    tbl.push_back(mk(1, 32'h102, 32'h12345678, 3'b010, 1, 32'h0,        1, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b010, 1, 32'hABFF1234, 0, 0));
    tbl.push_back(mk(0, 32'h101, 32'h0,        3'b010, 1, 32'h0,        1, 0));
    tbl.push_back(mk(0, 32'h103, 32'h0,        3'b001, 1, 32'h0,        1, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b011, 1, 32'h0,        1, 0));
    tbl.push_back(mk(1, 32'h100, 32'h0,        3'b110, 1, 32'h0,        1, 0));
    tbl.push_back(mk(0, 32'h100, 32'h0,        3'b010, 1, 32'hABFF1234, 0, 0));
    tbl.push_back(mk(0, 32'h1000, 32'h0,       3'b010, 1, 32'h0,        0, 1));
    tbl.push_back(mk(1, 32'h1000, 32'hDEADBEEF, 3'b010, 1, 32'h0,       0, 1));
    tbl.push_back(mk(0, 32'h0,   32'h0,        3'b010, 1, 32'h0,        0, 0));
    tbl.push_back(mk(1, 32'hFFC, 32'h5A5A5A5A, 3'b010, 1, 32'h0,        0, 0));
    tbl.push_back(mk(0, 32'hFFC, 32'h0,        3'b010, 1, 32'h5A5A5A5A, 0, 0));
    tbl.push_back(mk(0, 32'hFFF, 32'h0,        3'b100, 1, 32'h0000005A, 0, 0));

    foreach (tbl[i]) begin
      WE = tbl[i].we; A = tbl[i].a; WD = tbl[i].wd; funct3 = tbl[i].f3;
      #2;
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), RD, tbl[i].rd);
      chk($sformatf("vec%0d_mis", i), {31'd0, misalign},  {31'd0, tbl[i].mis});
      chk($sformatf("vec%0d_rng", i), {31'd0, range_err}, {31'd0, tbl[i].rng});
      tick();
      WE = 1'b0;
    end

    // Range window of a second instance that has a nonzero base.
    A2 = 32'h1FFC; #2; chk("hi_below_base", {31'd0, range_err2}, 32'd1);
    A2 = 32'h2000; #2; chk("hi_base",       {31'd0, range_err2}, 32'd0);
    A2 = 32'h2FFC; #2; chk("hi_top_word",   {31'd0, range_err2}, 32'd0);
    A2 = 32'h3000; #2; chk("hi_past_top",   {31'd0, range_err2}, 32'd1);

    // A store in READY, then a reset, then a second reset partway through the clear.
    store(32'h8, 32'h2222_2222, 3'b010);
    load(32'h8, 3'b010); chk("ready_store", RD, 32'h2222_2222);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 500; k++) tick();
    chk("mid_clear_busy", {31'd0, busy}, 32'd1);
    load(32'h8, 3'b010); chk("mid_clear_rd", RD, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_clear("clear2");
    load(32'h8, 3'b010);  chk("restart_zeroed", RD, 32'd0);
    load(32'h100, 3'b010); chk("restart_zeroed_100", RD, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
